// File: rtl/key_event_ctrl.sv
// PS/2 scan-code sequencer: decodes E0/F0 prefixes, tracks four held game keys and
// resolves per-player up/down conflicts into registered paddle commands plus key events.
module key_event_ctrl #(
    parameter int         TIMEOUT_CYCLES = 6_500_000,
    parameter logic [7:0] P1_UP_CODE     = 8'h1D,
    parameter logic [7:0] P1_DOWN_CODE   = 8'h1B,
    parameter logic [7:0] P2_UP_CODE     = 8'h75,
    parameter logic [7:0] P2_DOWN_CODE   = 8'h72
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       clear,
    output logic       p1_up,
    output logic       p1_down,
    output logic       p2_up,
    output logic       p2_down,
    output logic       ev_valid,
    output logic [1:0] ev_key,
    output logic       ev_make,
    output logic       seq_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       held;
    logic [3:0]       held_nx;
    // One bit per player: 1 means down was the most recent press, 0 means up.
    logic [1:0]       last;
    logic [1:0]       last_nx;

    logic       is_e0;
    logic       is_f0;
    logic       is_ignored;
    logic       is_code;
    logic       code_ext;
    logic       code_make;
    logic       key_hit;
    logic [1:0] key_idx;
    logic       ev_nx;
    logic       ev_make_nx;

    // Most recently pressed direction wins while both keys of a player are held.
    function automatic logic [3:0] resolve(input logic [3:0] h, input logic [1:0] l);
        logic [3:0] o;
        for (int p = 0; p < 2; p++) begin
            o[2*p]   = h[2*p]   & (~h[2*p+1] | ~l[p]);
            o[2*p+1] = h[2*p+1] & (~h[2*p]   |  l[p]);
        end
        return o;
    endfunction

    always_comb begin
        is_e0      = (byte_data == 8'hE0);
        is_f0      = (byte_data == 8'hF0);
        is_ignored = (state == S_IDLE) &&
                     (byte_data inside {8'hE1, 8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF});
        is_code    = !is_e0 && !is_f0 && !is_ignored;
        code_ext   = (state == S_EXT) || (state == S_EXT_BRK);
        code_make  = (state == S_IDLE) || (state == S_EXT);

        if (is_e0)
            state_nx = S_EXT;
        else if (is_f0)
            state_nx = code_ext ? S_EXT_BRK : S_BRK;
        else
            state_nx = S_IDLE;

        key_hit = 1'b0;
        key_idx = 2'd0;
        if (!code_ext && byte_data == P1_UP_CODE) begin
            key_hit = 1'b1;
            key_idx = 2'd0;
        end else if (!code_ext && byte_data == P1_DOWN_CODE) begin
            key_hit = 1'b1;
            key_idx = 2'd1;
        end else if (code_ext && byte_data == P2_UP_CODE) begin
            key_hit = 1'b1;
            key_idx = 2'd2;
        end else if (code_ext && byte_data == P2_DOWN_CODE) begin
            key_hit = 1'b1;
            key_idx = 2'd3;
        end

        held_nx    = held;
        last_nx    = last;
        ev_nx      = 1'b0;
        ev_make_nx = 1'b0;
        if (is_code && key_hit) begin
            if (code_make && !held[key_idx]) begin
                held_nx[key_idx]    = 1'b1;
                last_nx[key_idx[1]] = key_idx[0];
                ev_nx               = 1'b1;
                ev_make_nx          = 1'b1;
            end else if (!code_make && held[key_idx]) begin
                held_nx[key_idx] = 1'b0;
                ev_nx            = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            held     <= '0;
            last     <= '0;
            p1_up    <= 1'b0;
            p1_down  <= 1'b0;
            p2_up    <= 1'b0;
            p2_down  <= 1'b0;
            ev_valid <= 1'b0;
            ev_key   <= 2'd0;
            ev_make  <= 1'b0;
            seq_err  <= 1'b0;
        end else begin
            ev_valid <= 1'b0;
            seq_err  <= 1'b0;
            if (clear) begin
                state <= S_IDLE;
                cnt   <= '0;
                held  <= '0;
                last  <= '0;
                {p2_down, p2_up, p1_down, p1_up} <= 4'b0000;
            end else if (byte_valid) begin
                state    <= state_nx;
                cnt      <= '0;
                held     <= held_nx;
                last     <= last_nx;
                ev_valid <= ev_nx;
                if (ev_nx) begin
                    ev_key  <= key_idx;
                    ev_make <= ev_make_nx;
                end
                {p2_down, p2_up, p1_down, p1_up} <= resolve(held_nx, last_nx);
            end else if (state != S_IDLE) begin
                // A prefix with no follow-up byte is abandoned; held keys survive.
                if (cnt == CNT_LAST) begin
                    state   <= S_IDLE;
                    cnt     <= '0;
                    seq_err <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Randomized and directed bench for key_event_ctrl: a prefix/held-key reference model
// feeds an expected-event queue that a free-running monitor drains against the DUT.
module tb_key_event_ctrl;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       clear = 1'b0;
    logic       p1_up, p1_down, p2_up, p2_down;
    logic       ev_valid;
    logic [1:0] ev_key;
    logic       ev_make;
    logic       seq_err;

    key_event_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .clear(clear), .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up),
        .p2_down(p2_down), .ev_valid(ev_valid), .ev_key(ev_key), .ev_make(ev_make),
        .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit       serr;
        bit [1:0] key;
        bit       make;
        bit [3:0] outs;
        int       at;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model: pending prefixes, held keys, most recent direction per player.
    bit       m_ext, m_brk;
    bit [3:0] m_held;
    bit [1:0] m_lastdn;
    int       m_last_e;

    function automatic bit [3:0] m_outs();
        bit [3:0] o;
        for (int p = 0; p < 2; p++) begin
            o[2*p]   = m_held[2*p]   && (!m_held[2*p+1] || !m_lastdn[p]);
            o[2*p+1] = m_held[2*p+1] && (!m_held[2*p]   ||  m_lastdn[p]);
        end
        return o;
    endfunction

    function automatic int key_of(bit [7:0] b, bit ext);
        if (!ext && b == 8'h1D) return 0;
        if (!ext && b == 8'h1B) return 1;
        if ( ext && b == 8'h75) return 2;
        if ( ext && b == 8'h72) return 3;
        return -1;
    endfunction

    // An unfinished prefix older than T cycles at edge e has already timed out.
    task automatic m_timeout(input int e);
        exp_t x;
        if ((m_ext || m_brk) && (e - m_last_e > T)) begin
            x.serr = 1; x.key = 0; x.make = 0; x.outs = m_outs(); x.at = m_last_e + T;
            q.push_back(x);
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic m_byte(input bit [7:0] b, input int e);
        int   k;
        exp_t x;
        m_timeout(e);
        m_last_e = e;
        if (b == 8'hE0) begin
            m_ext = 1; m_brk = 0;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (!m_ext && !m_brk &&
                     (b == 8'hE1 || b == 8'h00 || b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hFF)) begin
        end else begin
            k = key_of(b, m_ext);
            if (k >= 0) begin
                if (!m_brk && !m_held[k]) begin
                    m_held[k] = 1;
                    m_lastdn[k/2] = k[0];
                    x.serr = 0; x.key = 2'(k); x.make = 1; x.outs = m_outs(); x.at = e;
                    q.push_back(x);
                end else if (m_brk && m_held[k]) begin
                    m_held[k] = 0;
                    x.serr = 0; x.key = 2'(k); x.make = 0; x.outs = m_outs(); x.at = e;
                    q.push_back(x);
                end
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic m_reset();
        m_ext = 0; m_brk = 0; m_held = 0; m_lastdn = 0; m_last_e = 0;
    endtask

    // All stimulus tasks start and end just after a falling edge.
    task automatic send(input bit [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        m_byte(b, cyc + 1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        m_timeout(cyc + 1 + n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clear(input bit with_byte, input bit [7:0] b);
        m_timeout(cyc + 1);
        clear = 1'b1;
        if (with_byte) begin
            byte_valid = 1'b1;
            byte_data  = b;
        end
        m_held = 0; m_lastdn = 0; m_ext = 0; m_brk = 0;
        @(negedge clk);
        clear = 1'b0;
        byte_valid = 1'b0;
    endtask

    task automatic do_reset();
        m_timeout(cyc + 1);
        rst = 1'b1;
        m_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_outs(input string name);
        n_vec++;
        if ({p2_down, p2_up, p1_down, p1_up} !== m_outs()) begin
            n_miss++;
            $display("FAIL %s: outs got=%b want=%b (cyc %0d)", name,
                     {p2_down, p2_up, p1_down, p1_up}, m_outs(), cyc);
        end
    endtask

    task automatic drain(input string name);
        idle(T + 4);
        n_vec++;
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL %s: %0d expected events never seen, required 0", name, q.size());
            q.delete();
        end
        check_outs(name);
    endtask

    initial begin : monitor
        exp_t x;
        bit [1:0] gk;
        bit       gm;
        forever begin
            @(negedge clk);
            if (ev_valid || seq_err) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_miss++;
                    $display("FAIL unexpected_event: ev_valid=%0b seq_err=%0b key=%0d make=%0b cyc=%0d, required none",
                             ev_valid, seq_err, ev_key, ev_make, cyc);
                end else begin
                    x  = q.pop_front();
                    gk = seq_err ? 2'd0 : ev_key;
                    gm = seq_err ? 1'b0 : ev_make;
                    if (ev_valid == x.serr || seq_err != x.serr || gk != x.key || gm != x.make ||
                        {p2_down, p2_up, p1_down, p1_up} != x.outs || cyc != x.at) begin
                        n_miss++;
                        $display("FAIL event: got ev=%0b serr=%0b key=%0d make=%0b outs=%b cyc=%0d; want serr=%0b key=%0d make=%0b outs=%b cyc=%0d",
                                 ev_valid, seq_err, gk, gm, {p2_down, p2_up, p1_down, p1_up}, cyc,
                                 x.serr, x.key, x.make, x.outs, x.at);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    bit [7:0] pool [12] = '{8'h1D, 8'h1B, 8'h75, 8'h72, 8'hE0, 8'hF0,
                            8'hE0, 8'hF0, 8'hAA, 8'h1D, 8'h75, 8'h33};

    initial begin : stim
        int r;
        m_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if ({ev_valid, seq_err, p2_down, p2_up, p1_down, p1_up} !== 6'b0) begin
            n_miss++;
            $display("FAIL reset_state: got %b want 000000", {ev_valid, seq_err, p2_down, p2_up, p1_down, p1_up});
        end
        rst = 1'b0;
        @(negedge clk);
        check_outs("after_reset");

        send(8'h1D);                          drain("p1_up_make");
        send(8'hF0); send(8'h1D);             drain("p1_up_break");
        send(8'hE0); send(8'h75);             drain("p2_up_make");
        send(8'h75);                          drain("plain_75_ignored");
        send(8'hE0); send(8'hF0); send(8'h75); drain("p2_up_break");
        send(8'h1D); send(8'h1B);             drain("conflict_down_wins");
        send(8'hF0); send(8'h1B);             drain("handback_up");
        send(8'hF0); send(8'h1D);             drain("release_all_p1");
        send(8'h1D); send(8'h1D); send(8'h1D); drain("typematic");
        send(8'hF0); send(8'h1D);             drain("typematic_release");
        send(8'hE0); idle(T + 3); send(8'h75); drain("timeout_then_plain");
        send(8'hE0); idle(T - 1); send(8'h75); drain("gap_at_limit");
        send(8'hE0); send(8'hF0); idle(T); send(8'h75); drain("gap_past_limit");
        send(8'hE0); send(8'hF0); send(8'h75); drain("p2_release");
        send(8'h1D); do_clear(1'b1, 8'h1B);    drain("clear_with_byte");
        send(8'hF0); send(8'h1D);             drain("break_after_clear");
        send(8'hE0); idle(T - 1); do_clear(1'b0, 8'h00); drain("clear_at_timeout");
        send(8'hE0); send(8'hF0); do_reset(); send(8'h72); drain("reset_mid_seq");

        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 4)
                do_clear($urandom_range(0, 1) == 1, pool[$urandom_range(0, 11)]);
            else if (r < 6)
                do_reset();
            else if (r < 11)
                idle(T + $urandom_range(0, 3));
            else begin
                send(pool[$urandom_range(0, 11)]);
                if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3));
            end
            if (i % 100 == 99) drain("random_block");
        end
        drain("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
